// File: rtl/contador_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : contador_arb_if
// Brief    : Requester handshake plus shared up/down counter bus for contador_arb.
// Revision : 1.0
// ============================================================================
interface contador_arb_if #(
    parameter int W = 2
) ();
    logic         req0;
    logic         up0;
    logic         req1;
    logic         up1;
    logic         ack0;
    logic         err0;
    logic         ack1;
    logic         err1;
    logic         busy;
    logic         nxt;
    logic         dir;
    logic         empty;
    logic         full;
    logic         mismatch;
    logic [W-1:0] cuenta;

    // Requesters and the counter side together form the "master" environment.
    modport master (
        output req0, up0, req1, up1, empty, full, cuenta,
        input  ack0, err0, ack1, err1, busy, nxt, dir, mismatch
    );

    modport slave (
        input  req0, up0, req1, up1, empty, full, cuenta,
        output ack0, err0, ack1, err1, busy, nxt, dir, mismatch
    );
endinterface
`default_nettype wire

// File: rtl/contador_arb.sv
`default_nettype none
// ============================================================================
// Module   : contador_arb
// Brief    : Two-requester round-robin step controller for a shared up/down
//            occupancy counter. Optional shadow check via CTRL_SHADOW_EN.
// Revision : 1.0
// ============================================================================
module contador_arb #(
    parameter int W        = 2,
    parameter int HOLD_CYC = 1
) (
    input  wire logic      clk,
    input  wire logic      rst,
    contador_arb_if.slave  bus
);

    if (W < 1) begin : g_bad_width
        $error("contador_arb: W must be at least 1");
    end
    if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
        $error("contador_arb: HOLD_CYC must be in 1..15");
    end

    localparam logic [3:0] c_hold_last = 4'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        PULSE   = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic       r_last_grant;
    logic       r_id;
    logic       r_dir;
    logic       r_err0;
    logic       r_err1;
    logic [3:0] r_hold_cnt;

    logic       w_req0;
    logic       w_req1;
    logic       w_any;
    logic       w_winner;
    logic       w_up;
    logic       w_illegal;
    logic       w_sample;
    logic       w_grant_ok;
    logic       w_grant_bad;
    logic       w_hold_done;

    logic       w_nxt;
    logic       w_busy;
    logic       w_ack0;
    logic       w_ack1;

    // Requests are masked during any err cycle so a held req is never
    // re-evaluated before the requester has seen its rejection.
    always_comb begin
        w_req0      = bus.req0 & ~r_err0 & ~r_err1;
        w_req1      = bus.req1 & ~r_err0 & ~r_err1;
        w_any       = w_req0 | w_req1;
        w_winner    = (w_req0 & w_req1) ? ~r_last_grant : w_req1;
        w_up        = w_winner ? bus.up1 : bus.up0;
        w_illegal   = (w_up & bus.full) | (~w_up & bus.empty);
        w_sample    = (r_state == IDLE) & w_any;
        w_grant_ok  = w_sample & ~w_illegal;
        w_grant_bad = w_sample & w_illegal;
        w_hold_done = (r_hold_cnt == c_hold_last);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_nxt       = 1'b0;
        w_busy      = 1'b0;
        w_ack0      = 1'b0;
        w_ack1      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_ok) begin
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                w_busy      = 1'b1;
                w_state_nxt = PULSE;
            end
            PULSE: begin
                w_busy = 1'b1;
                w_nxt  = 1'b1;
                if (w_hold_done) begin
                    w_state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                w_busy      = 1'b1;
                w_state_nxt = DONE;
            end
            DONE: begin
                w_busy      = 1'b1;
                w_ack0      = ~r_id;
                w_ack1      = r_id;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // last_grant follows every IDLE decision, rejected or not, so a stuck
    // illegal requester cannot starve the other one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_dir        <= 1'b0;
            r_err0       <= 1'b0;
            r_err1       <= 1'b0;
            r_hold_cnt   <= 4'd0;
        end else begin
            r_err0 <= w_grant_bad & ~w_winner;
            r_err1 <= w_grant_bad & w_winner;
            if (w_sample) begin
                r_last_grant <= w_winner;
            end
            if (w_grant_ok) begin
                r_id  <= w_winner;
                r_dir <= w_up;
            end
            if (r_state == PULSE) begin
                r_hold_cnt <= r_hold_cnt + 4'd1;
            end else begin
                r_hold_cnt <= 4'd0;
            end
        end
    end

    assign bus.nxt  = w_nxt;
    assign bus.busy = w_busy;
    assign bus.ack0 = w_ack0;
    assign bus.ack1 = w_ack1;
    assign bus.err0 = r_err0;
    assign bus.err1 = r_err1;
    assign bus.dir  = r_dir;

`ifdef CTRL_SHADOW_EN
    logic [W-1:0] r_shadow;
    logic [W-1:0] w_expect;
    logic         r_mismatch;

    // Wraps modulo 2^W, matching a counter that rolls over.
    always_comb begin
        w_expect = r_dir ? (r_shadow + W'(1)) : (r_shadow - W'(1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shadow   <= '0;
            r_mismatch <= 1'b0;
        end else begin
            if (w_grant_ok) begin
                r_shadow <= bus.cuenta;
            end
            if ((r_state == DONE) && (bus.cuenta != w_expect)) begin
                r_mismatch <= 1'b1;
            end
        end
    end

    assign bus.mismatch = r_mismatch;
`else
    logic w_unused_cuenta;
    assign w_unused_cuenta = ^bus.cuenta;
    assign bus.mismatch    = 1'b0;
`endif

    a_pulse_onehot: assert property (@(posedge clk) disable iff (!rst)
        $onehot0({bus.ack0, bus.err0, bus.ack1, bus.err1}));

    a_nxt_busy: assert property (@(posedge clk) disable iff (!rst)
        bus.nxt |-> bus.busy);

endmodule
`default_nettype wire

// File: tb/tb_contador_arb.sv
`default_nettype none
// Scoreboard bench for contador_arb: directed requests push expected
// ack/err responses; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_contador_arb;
    localparam int W = 2;
`ifdef CTRL_SHADOW_EN
    localparam bit C_MM = 1'b1;
`else
    localparam bit C_MM = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    logic ctr_clr;
    logic freeze;
    logic nxt_qa;
    logic nxt_qb;
    int   cyc     = 0;
    int   steps_a = 0;
    int   acks_b  = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    contador_arb_if #(.W(W)) ifa ();
    contador_arb_if #(.W(W)) ifb ();

    contador_arb #(.W(W), .HOLD_CYC(1)) u_dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
    contador_arb #(.W(W), .HOLD_CYC(3)) u_dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

    // External counters: one step per rising edge of nxt.
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        nxt_qa <= ifa.nxt;
        nxt_qb <= ifb.nxt;
        if (ctr_clr) begin
            ifa.cuenta <= '0;
            ifb.cuenta <= '0;
        end else begin
            if (ifa.nxt && !nxt_qa) begin
                steps_a <= steps_a + 1;
                if (!freeze) ifa.cuenta <= ifa.dir ? ifa.cuenta + 2'd1 : ifa.cuenta - 2'd1;
            end
            if (ifb.nxt && !nxt_qb)
                ifb.cuenta <= ifb.dir ? ifb.cuenta + 2'd1 : ifb.cuenta - 2'd1;
        end
    end
    assign ifa.empty = (ifa.cuenta == 2'd0);
    assign ifa.full  = (ifa.cuenta == 2'd3);
    assign ifb.empty = (ifb.cuenta == 2'd0);
    assign ifb.full  = (ifb.cuenta == 2'd3);

    typedef struct {
        bit           is_err;
        bit           id;
        logic [W-1:0] cnt;
        int           at;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input bit is_err, input bit id, input logic [W-1:0] cnt, input int at);
        exp_t e;
        e.is_err = is_err;
        e.id     = id;
        e.cnt    = cnt;
        e.at     = at;
        sbq.push_back(e);
    endtask

    task automatic wait_pulse(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(ifa.ack0 | ifa.err0 | ifa.ack1 | ifa.err1) && k < 40);
        chk({name, "_seen"}, (ifa.ack0 | ifa.err0 | ifa.ack1 | ifa.err1), 1);
    endtask

    always @(negedge clk) begin
        if (rst_a === 1'b1 && (ifa.ack0 | ifa.err0 | ifa.ack1 | ifa.err1)) begin
            chk("pulse_onehot", $countones({ifa.ack0, ifa.err0, ifa.ack1, ifa.err1}), 1);
            chk("expected_pending", sbq.size() > 0, 1);
            if (sbq.size() > 0) begin
                mon_e = sbq.pop_front();
                chk("pulse_is_err", ifa.err0 | ifa.err1, mon_e.is_err);
                chk("pulse_id", ifa.ack1 | ifa.err1, mon_e.id);
                chk("cuenta_at_pulse", ifa.cuenta, mon_e.cnt);
                if (mon_e.at >= 0) chk("pulse_latency", cyc, mon_e.at);
            end
        end
        if (ifb.ack0 | ifb.ack1) acks_b <= acks_b + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int s0;
        rst_a = 1'b0; rst_b = 1'b0; ctr_clr = 1'b1; freeze = 1'b0;
        ifa.req0 = 0; ifa.up0 = 0; ifa.req1 = 0; ifa.up1 = 0;
        ifb.req0 = 0; ifb.up0 = 0; ifb.req1 = 0; ifb.up1 = 0;
        repeat (2) @(negedge clk);
        chk("reset_outs_a", {ifa.ack0, ifa.err0, ifa.ack1, ifa.err1, ifa.busy, ifa.nxt, ifa.dir, ifa.mismatch}, 0);
        chk("reset_outs_b", {ifb.ack0, ifb.err0, ifb.ack1, ifb.err1, ifb.busy, ifb.nxt, ifb.dir, ifb.mismatch}, 0);
        rst_a = 1'b1; rst_b = 1'b1; ctr_clr = 1'b0;
        @(negedge clk);

        // Empty reject: down request from requester 1 at cuenta 0.
        s0 = steps_a;
        ifa.req1 = 1; ifa.up1 = 0;
        push(1, 1, 2'd0, cyc + 1);
        wait_pulse("empty_rej");
        ifa.req1 = 0;
        @(negedge clk);
        chk("empty_rej_no_nxt", steps_a - s0, 0);
        chk("empty_rej_dir", ifa.dir, 0);
        chk("empty_rej_busy", ifa.busy, 0);

        // Single increment with per-phase checks of {busy,dir,nxt}.
        s0 = steps_a;
        ifa.req0 = 1; ifa.up0 = 1;
        push(0, 0, 2'd1, cyc + 4);
        @(negedge clk); chk("inc_setup", {ifa.busy, ifa.dir, ifa.nxt}, 3'b110);
        @(negedge clk); chk("inc_pulse", {ifa.busy, ifa.dir, ifa.nxt}, 3'b111);
        @(negedge clk); chk("inc_release", {ifa.busy, ifa.dir, ifa.nxt}, 3'b110);
        wait_pulse("inc_ack");
        chk("inc_done_busy", ifa.busy, 1);
        ifa.req0 = 0;
        @(negedge clk);
        chk("inc_idle_busy", ifa.busy, 0);
        chk("inc_one_step", steps_a - s0, 1);

        // Decrement back to empty via requester 1.
        ifa.req1 = 1; ifa.up1 = 0;
        push(0, 1, 2'd0, cyc + 4);
        wait_pulse("dec_ack");
        ifa.req1 = 0;
        @(negedge clk);

        // Round robin from empty: tie goes to 0, then alternates.
        ifa.req0 = 1; ifa.up0 = 1; ifa.req1 = 1; ifa.up1 = 1;
        push(0, 0, 2'd1, cyc + 4);
        push(0, 1, 2'd2, -1);
        push(0, 0, 2'd3, -1);
        for (int i = 0; i < 3; i++) wait_pulse("rr_ack");
        ifa.req0 = 0; ifa.req1 = 0;
        @(negedge clk);
        chk("rr_full_flag", ifa.full, 1);
        chk("rr_no_mismatch", ifa.mismatch, 0);

        // Full, both asking up: err owner alternates per retry window.
        s0 = steps_a;
        ifa.req0 = 1; ifa.up0 = 1; ifa.req1 = 1; ifa.up1 = 1;
        push(1, 1, 2'd3, cyc + 1);
        push(1, 0, 2'd3, cyc + 3);
        push(1, 1, 2'd3, cyc + 5);
        for (int i = 0; i < 3; i++) wait_pulse("full_rej");
        ifa.req0 = 0; ifa.req1 = 0;
        @(negedge clk);
        chk("full_rej_no_nxt", steps_a - s0, 0);
        chk("full_rej_busy", ifa.busy, 0);

        // Full, up vs down: up wins the round robin and is rejected.
        ifa.req0 = 1; ifa.up0 = 1; ifa.req1 = 1; ifa.up1 = 0;
        push(1, 0, 2'd3, cyc + 1);
        push(0, 1, 2'd2, -1);
        wait_pulse("mix_err");
        ifa.req0 = 0;
        wait_pulse("mix_ack");
        ifa.req1 = 0;
        @(negedge clk);

        // Counter refuses to move during a legal step.
        freeze = 1'b1;
        ifa.req0 = 1; ifa.up0 = 1;
        push(0, 0, 2'd2, cyc + 4);
        wait_pulse("frz_ack");
        ifa.req0 = 0;
        @(negedge clk);
        chk("mismatch_set", ifa.mismatch, C_MM);
        repeat (5) @(negedge clk);
        chk("mismatch_sticky", ifa.mismatch, C_MM);
        freeze = 1'b0;
        rst_a = 1'b0;
        @(negedge clk);
        chk("mismatch_cleared", ifa.mismatch, 0);
        rst_a = 1'b1;
        @(negedge clk);

        // Reset during the second PULSE cycle on the HOLD_CYC=3 instance.
        ifb.req0 = 1; ifb.up0 = 1;
        @(negedge clk); chk("b_setup", {ifb.busy, ifb.nxt}, 2'b10);
        @(negedge clk); chk("b_pulse1", ifb.nxt, 1);
        @(negedge clk); chk("b_pulse2", ifb.nxt, 1);
        rst_b = 1'b0;
        ifb.req0 = 0;
        @(negedge clk);
        chk("b_rst_nxt", ifb.nxt, 0);
        chk("b_rst_busy", ifb.busy, 0);
        rst_b = 1'b1;
        repeat (6) @(negedge clk);
        chk("b_no_ack", acks_b, 0);
        chk("b_idle", {ifb.busy, ifb.nxt}, 0);

        chk("sb_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
